seq_mult_shift_add: RTL and testbench

- Parametrised sequential shift-and-add multiplier; next generation of the team's combinational 4x4 array multiplier.
- Computes WIDTH x WIDTH -> 2*WIDTH products, one partial product per clock.
- Supports unsigned and two's-complement signed operands, selected per operation.
- Start/busy/done handshake and synchronous abort; sits between the pin-level input registers and the output mux of the tile.

---
 rtl/seq_mult_shift_add.sv | 67 ++++++
 tb/tb_seq_mult_shift_add.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_shift_add.sv
// seq_mult_shift_add: sequential shift-and-add WIDTH x WIDTH multiplier, signed or unsigned per operation
module seq_mult_shift_add #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;
    localparam int CW = $clog2(WIDTH + 1);
    state_t             state, state_nxt;
    logic [WIDTH-1:0]   mcand, mplier, a_mag, b_mag;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg, a_neg, b_neg;
    logic [WIDTH:0]     sum;
    always_comb begin
        a_neg     = signed_mode & a[WIDTH-1];
        b_neg     = signed_mode & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mplier[0] ? mcand : '0};
        busy      = state != IDLE;
        state_nxt = abort            ? IDLE :
                    state == IDLE    ? (start ? RUN : IDLE) :
                    state == RUN     ? (cnt == CW'(WIDTH - 1) ? SIGN : RUN) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            if (state == IDLE && start && !abort) begin
                mcand  <= a_mag;
                mplier <= b_mag;
                neg    <= a_neg ^ b_neg;
                acc    <= '0;
                cnt    <= '0;
            end
            // carry out of the add becomes the new MSB as the accumulator shifts right
            if (state == RUN && !abort) begin
                acc    <= (2*WIDTH)'({sum, acc[WIDTH-1:0]} >> 1);
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
            end
            if (state == SIGN && !abort) begin
                product <= neg ? -acc : acc;
                done    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seq_mult_shift_add.sv
// tb_seq_mult_shift_add: checks WIDTH=4 and WIDTH=8 instances against an arithmetic reference model
module tb_seq_mult_shift_add;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic       st[2], ab[2], sm[2];
    logic [7:0] oa[2], ob[2];
    logic       busy4, busy8, done4, done8;
    logic [7:0] p4;
    logic [15:0] p8;
    logic       obz[2], odn[2];
    logic [15:0] opr[2];
    int n_tests = 0, n_fail = 0;

    seq_mult_shift_add #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .abort(ab[0]), .signed_mode(sm[0]),
        .a(oa[0][3:0]), .b(ob[0][3:0]), .busy(busy4), .done(done4), .product(p4));
    seq_mult_shift_add #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .abort(ab[1]), .signed_mode(sm[1]),
        .a(oa[1]), .b(ob[1]), .busy(busy8), .done(done8), .product(p8));

    always_comb begin
        obz[0] = busy4; obz[1] = busy8;
        odn[0] = done4; odn[1] = done8;
        opr[0] = {8'h00, p4}; opr[1] = p8;
    end

    function automatic int wd(int i);
        return i ? 8 : 4;
    endfunction

    // true mathematical product, reduced to the 2*w-bit result field
    function automatic logic [15:0] calc(int w, logic s, logic [7:0] x, logic [7:0] y);
        longint xv, yv, m;
        xv = longint'(x);
        yv = longint'(y);
        if (s && x[w-1]) xv -= longint'(1) << w;
        if (s && y[w-1]) yv -= longint'(1) << w;
        m = (longint'(1) << (2 * w)) - 1;
        return 16'((xv * yv) & m);
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    int          m_left[2] = '{0, 0};
    logic        m_done[2] = '{1'b0, 1'b0};
    logic [15:0] m_prod[2] = '{16'h0, 16'h0};
    logic [15:0] m_pend[2] = '{16'h0, 16'h0};

    // timing model: an accepted op occupies WIDTH+1 edges and completes with the arithmetic product
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_left[i] = 0; m_done[i] = 1'b0; m_prod[i] = '0;
            end else begin
                m_done[i] = 1'b0;
                if (m_left[i] > 0) begin
                    if (ab[i]) m_left[i] = 0;
                    else begin
                        m_left[i]--;
                        if (m_left[i] == 0) begin
                            m_done[i] = 1'b1;
                            m_prod[i] = m_pend[i];
                        end
                    end
                end else if (st[i] && !ab[i]) begin
                    m_left[i] = wd(i) + 1;
                    m_pend[i] = calc(wd(i), sm[i], oa[i], ob[i]);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk(i ? "busy8" : "busy4", {15'h0, obz[i]}, {15'h0, m_left[i] > 0});
            chk(i ? "done8" : "done4", {15'h0, odn[i]}, {15'h0, m_done[i]});
            chk(i ? "prod8" : "prod4", opr[i], m_prod[i]);
        end
    end

    task automatic issue(int i, logic s, logic [7:0] x, logic [7:0] y);
        sm[i] = s; oa[i] = x; ob[i] = y; st[i] = 1'b1;
        @(negedge clk);
        st[i] = 1'b0;
    endtask

    // waits for done while churning operands and firing stray starts that must be ignored
    task automatic wait_done(int i, output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (odn[i]) begin
                st[i] = 1'b0;
                break;
            end
            if (lat > 40) begin
                st[i] = 1'b0;
                chk("done_timeout", 16'(lat), 16'(wd(i) + 1));
                break;
            end
            st[i] = ($urandom_range(0, 3) == 0);
            oa[i] = 8'($urandom) & (i ? 8'hFF : 8'h0F);
            ob[i] = 8'($urandom) & (i ? 8'hFF : 8'h0F);
            sm[i] = 1'($urandom);
        end
    endtask

    task automatic run(int i, logic s, logic [7:0] x, logic [7:0] y, logic [15:0] exp, string name);
        int lat;
        issue(i, s, x, y);
        wait_done(i, lat);
        chk({name, "_lat"}, 16'(lat), 16'(wd(i) + 1));
        chk(name, opr[i], exp);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 2; i++) begin
            st[i] = 0; ab[i] = 0; sm[i] = 0; oa[i] = 0; ob[i] = 0;
        end
        chk("pin_u15x15", calc(4, 1'b0, 8'h0F, 8'h0F), 16'h00E1);
        chk("pin_sD_x5", calc(4, 1'b1, 8'h0D, 8'h05), 16'h00F1);
        chk("pin_s80x7F", calc(8, 1'b1, 8'h80, 8'h7F), 16'hC080);
        repeat (3) @(negedge clk);
        chk("rst_busy", {15'h0, busy4}, 16'h0);
        chk("rst_prod", opr[0], 16'h0);
        rst_n = 1'b1;
        @(negedge clk);
        run(0, 1'b0, 8'h0F, 8'h0F, 16'h00E1, "u15x15");
        repeat (3) @(negedge clk);
        chk("hold_E1", opr[0], 16'h00E1);
        run(0, 1'b1, 8'h08, 8'h08, 16'h0040, "s8x8");
        run(0, 1'b1, 8'h0D, 8'h05, 16'h00F1, "sDx5");
        run(0, 1'b1, 8'h00, 8'h09, 16'h0000, "s0x9");
        issue(0, 1'b0, 8'h03, 8'h04);
        wait_done(0, lat);
        chk("b2b_first", opr[0], 16'h000C);
        run(0, 1'b0, 8'h07, 8'h02, 16'h000E, "b2b_second");
        issue(0, 1'b0, 8'h09, 8'h09);
        ab[0] = 1'b1;
        @(negedge clk);
        ab[0] = 1'b0;
        chk("abort_busy", {15'h0, busy4}, 16'h0);
        repeat (8) @(negedge clk);
        chk("abort_prod", opr[0], 16'h000E);
        st[0] = 1'b1; ab[0] = 1'b1; oa[0] = 8'h03; ob[0] = 8'h03;
        @(negedge clk);
        st[0] = 1'b0; ab[0] = 1'b0;
        chk("abort_wins", {15'h0, busy4}, 16'h0);
        run(0, 1'b0, 8'h02, 8'h03, 16'h0006, "after_abort");
        issue(0, 1'b0, 8'h09, 8'h09);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {15'h0, busy4}, 16'h0);
        chk("arst_done", {15'h0, done4}, 16'h0);
        chk("arst_prod", opr[0], 16'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run(0, 1'b0, 8'h05, 8'h05, 16'h0019, "post_rst");
        run(1, 1'b0, 8'hFF, 8'hFF, 16'hFE01, "u255x255");
        run(1, 1'b1, 8'h80, 8'h7F, 16'hC080, "sm128x127");
        run(1, 1'b1, 8'h80, 8'h80, 16'h4000, "sm128sq");
        for (int k = 0; k < 1000; k++) begin
            issue(1, 1'($urandom), 8'($urandom), 8'($urandom));
            wait_done(1, lat);
            chk("rand8_lat", 16'(lat), 16'd9);
        end
        for (int k = 0; k < 200; k++) begin
            issue(0, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
            wait_done(0, lat);
            chk("rand4_lat", 16'(lat), 16'd5);
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
